// File: rtl/cv32e40p_wb_queue_if.sv
// Bundle for the pending-write queue: producer push channel, W2 write port,
// drain control and the read-port hazard lookups.
interface cv32e40p_wb_queue_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                         push_valid_i;
    logic                         push_ready_o;
    logic [ADDR_WIDTH-1:0]        push_addr_i;
    logic [DATA_WIDTH-1:0]        push_data_i;
    logic                         port_busy_i;
    logic                         flush_i;
    logic                         we_b_o;
    logic [ADDR_WIDTH-1:0]        waddr_b_o;
    logic [DATA_WIDTH-1:0]        wdata_b_o;
    logic [ADDR_WIDTH-1:0]        raddr_a_i;
    logic [ADDR_WIDTH-1:0]        raddr_b_i;
    logic [ADDR_WIDTH-1:0]        raddr_c_i;
    logic                         hazard_a_o;
    logic                         hazard_b_o;
    logic                         hazard_c_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         empty_o;

    modport slave (
        input  push_valid_i, push_addr_i, push_data_i, port_busy_i, flush_i,
               raddr_a_i, raddr_b_i, raddr_c_i,
        output push_ready_o, we_b_o, waddr_b_o, wdata_b_o,
               hazard_a_o, hazard_b_o, hazard_c_o, count_o, empty_o
    );

    modport master (
        output push_valid_i, push_addr_i, push_data_i, port_busy_i, flush_i,
               raddr_a_i, raddr_b_i, raddr_c_i,
        input  push_ready_o, we_b_o, waddr_b_o, wdata_b_o,
               hazard_a_o, hazard_b_o, hazard_c_o, count_o, empty_o
    );
endinterface

// File: rtl/cv32e40p_wb_queue.sv
// In-order queue of completed long-latency results that drains into register
// file port W2 whenever the primary writer leaves it free.
module cv32e40p_wb_queue #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic                clk_int,
    input logic                rst_n,
    cv32e40p_wb_queue_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push_ready;
    logic                  push_stored;
    logic [DEPTH-1:0]      entry_valid;
    logic [PTR_WIDTH-1:0]  offset;
    logic                  hit_a;
    logic                  hit_b;
    logic                  hit_c;

    assign empty       = (count == '0);
    assign full        = (count == CNT_WIDTH'(DEPTH));
    assign pop         = !empty && !bus.port_busy_i && !bus.flush_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push_ready  = !bus.flush_i && (!full || pop);
    assign push_stored = bus.push_valid_i && push_ready && (bus.push_addr_i != '0);

    assign bus.push_ready_o = push_ready;
    assign bus.we_b_o       = pop;
    assign bus.waddr_b_o    = empty ? '0 : entry_addr[rd_ptr];
    assign bus.wdata_b_o    = empty ? '0 : entry_data[rd_ptr];
    assign bus.count_o      = count;
    assign bus.empty_o      = empty;

    // Hazard lookup covers only live entries, located by distance from the head.
    always_comb begin
        entry_valid = '0;
        offset      = '0;
        hit_a       = 1'b0;
        hit_b       = 1'b0;
        hit_c       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_WIDTH'(i) - rd_ptr;
            entry_valid[i] = (CNT_WIDTH'(offset) < count);
            if (entry_valid[i] && entry_addr[i] == bus.raddr_a_i) hit_a = 1'b1;
            if (entry_valid[i] && entry_addr[i] == bus.raddr_b_i) hit_b = 1'b1;
            if (entry_valid[i] && entry_addr[i] == bus.raddr_c_i) hit_c = 1'b1;
        end
    end

    assign bus.hazard_a_o = hit_a && (bus.raddr_a_i != '0);
    assign bus.hazard_b_o = hit_b && (bus.raddr_b_i != '0);
    assign bus.hazard_c_o = hit_c && (bus.raddr_c_i != '0);

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
            end
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_stored) begin
                entry_addr[wr_ptr] <= bus.push_addr_i;
                entry_data[wr_ptr] <= bus.push_data_i;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_WIDTH'(push_stored) - CNT_WIDTH'(pop);
        end
    end

    count_bounded: assert property (@(posedge clk_int) disable iff (!rst_n)
                                    count <= CNT_WIDTH'(DEPTH));
endmodule
